// File: rtl/jogo_pkg.sv
// Shared constants for the memory-game control unit.
//   estado_t       : 4-bit state code, also exported on db_estado
//   MSG_*          : displayAddr message selects
//   HITS_POR_PASSO : distinct correct hits needed to finish one sequence step
package jogo_pkg;

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    SELECIONA = 4'h1,
    PREPARA   = 4'h2,
    CARREGA   = 4'h3,
    ESPERA    = 4'h4,
    REGISTRA  = 4'h5,
    COMPARA   = 4'h6,
    ACERTO    = 4'h7,
    PISCA_ON  = 4'h8,
    PISCA_OFF = 4'h9,
    PROXIMA   = 4'hA,
    GANHOU    = 4'hB,
    PERDEU    = 4'hC
  } estado_t;

  localparam logic [1:0] MSG_MODO    = 2'b00;
  localparam logic [1:0] MSG_GANHOU  = 2'b01;
  localparam logic [1:0] MSG_ERRO    = 2'b10;
  localparam logic [1:0] MSG_TIMEOUT = 2'b11;

  localparam int unsigned HITS_POR_PASSO = 3;

  // Hit count seen in ACERTO when the hit being counted is the last of the step.
  localparam logic [1:0] ULTIMO_HIT = 2'(HITS_POR_PASSO - 1);

endpackage

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory game. Sequences fluxo_dados through mode
// selection, per-step LED pattern load, three distinct correct hits, a blink
// celebration and step advance, ending in GANHOU or PERDEU.
// Ports:
//   clock, reset (async, active-low)       : clocking
//   iniciar                                : start / restart level
//   tem_jogada, acertouJogada,
//   jogadaAtualEQUALSacertoAnterior,
//   acertoAnteriorEQUALSzero               : play status from the datapath
//   fimS, fimLedsOn, fimLedsOff,
//   fimPiscaLeds, timeout                  : counter status from the datapath
//   zera*/conta*/registra*                 : datapath strobes
//   displayFromMem, displayAddr            : message display select
//   apagarAcertos                          : blank the hit LEDs
//   pronto, ganhou, perdeu                 : game result
//   db_estado                              : current state code
module unidade_controle_jogo
  import jogo_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       acertouJogada,
  input  logic       jogadaAtualEQUALSacertoAnterior,
  input  logic       acertoAnteriorEQUALSzero,
  input  logic       fimS,
  input  logic       fimLedsOn,
  input  logic       fimLedsOff,
  input  logic       fimPiscaLeds,
  input  logic       timeout,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       zeraA,
  output logic       registraA,
  output logic       contaA,
  output logic       contaPiscadas,
  output logic       contaLedsOn,
  output logic       contaLedsOff,
  output logic       zeraL,
  output logic       registraL,
  output logic       contaM,
  output logic       zeraM,
  output logic       displayFromMem,
  output logic       apagarAcertos,
  output logic [1:0] displayAddr,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  estado_t    estado_q, estado_d;
  logic [1:0] hits_q, hits_d;
  // Remembers whether the loss was a timeout, to pick the PERDEU message.
  logic       perdeu_to_q, perdeu_to_d;

  // State register, hit counter and loss-cause flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      hits_q      <= '0;
      perdeu_to_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      hits_q      <= hits_d;
      perdeu_to_q <= perdeu_to_d;
    end
  end

  // Next-state logic.
  always_comb begin
    estado_d    = estado_q;
    hits_d      = hits_q;
    perdeu_to_d = perdeu_to_q;
    case (estado_q)
      INICIAL:   estado_d = SELECIONA;
      SELECIONA: if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        hits_d      = '0;
        perdeu_to_d = 1'b0;
        estado_d    = CARREGA;
      end
      CARREGA:   estado_d = ESPERA;
      ESPERA: begin
        // timeout wins over a simultaneous play
        if (timeout) begin
          estado_d    = PERDEU;
          perdeu_to_d = 1'b1;
        end else if (tem_jogada) begin
          estado_d = REGISTRA;
        end
      end
      REGISTRA:  estado_d = COMPARA;
      COMPARA: begin
        if (timeout) begin
          estado_d    = PERDEU;
          perdeu_to_d = 1'b1;
        end else if (!acertouJogada) begin
          estado_d = PERDEU;
        end else if (jogadaAtualEQUALSacertoAnterior && !acertoAnteriorEQUALSzero) begin
          // same button as the previous hit: not a new distinct hit
          estado_d = ESPERA;
        end else begin
          estado_d = ACERTO;
        end
      end
      ACERTO: begin
        hits_d   = hits_q + 2'd1;
        estado_d = (hits_q == ULTIMO_HIT) ? PISCA_ON : ESPERA;
      end
      PISCA_ON:  if (fimLedsOn) estado_d = PISCA_OFF;
      PISCA_OFF: begin
        if (fimLedsOff) estado_d = fimPiscaLeds ? PROXIMA : PISCA_ON;
      end
      PROXIMA: begin
        hits_d   = '0;
        estado_d = fimS ? GANHOU : CARREGA;
      end
      GANHOU:    if (iniciar) estado_d = PREPARA;
      PERDEU:    if (iniciar) estado_d = PREPARA;
      default:   estado_d = INICIAL;
    endcase
  end

  // Output decode; everything follows the registered state except contaS,
  // which also looks at fimS so the step counter stops on the last step.
  always_comb begin
    zeraT          = 1'b0;
    contaT         = 1'b0;
    zeraS          = 1'b0;
    contaS         = 1'b0;
    zeraR          = 1'b0;
    registraR      = 1'b0;
    zeraA          = 1'b0;
    registraA      = 1'b0;
    contaA         = 1'b0;
    contaPiscadas  = 1'b0;
    contaLedsOn    = 1'b0;
    contaLedsOff   = 1'b0;
    zeraL          = 1'b0;
    registraL      = 1'b0;
    contaM         = 1'b0;
    zeraM          = 1'b0;
    displayFromMem = 1'b0;
    apagarAcertos  = 1'b0;
    displayAddr    = MSG_MODO;
    pronto         = 1'b0;
    ganhou         = 1'b0;
    perdeu         = 1'b0;
    case (estado_q)
      INICIAL: begin
        zeraM         = 1'b1;
        apagarAcertos = 1'b1;
      end
      SELECIONA: begin
        contaM         = 1'b1;
        displayFromMem = 1'b1;
        displayAddr    = MSG_MODO;
        apagarAcertos  = 1'b1;
      end
      PREPARA: begin
        zeraT = 1'b1;
        zeraS = 1'b1;
        zeraR = 1'b1;
        zeraA = 1'b1;
        zeraL = 1'b1;
      end
      CARREGA:  registraL = 1'b1;
      ESPERA:   contaT = 1'b1;
      REGISTRA: begin
        contaT    = 1'b1;
        registraR = 1'b1;
      end
      COMPARA:  contaT = 1'b1;
      ACERTO: begin
        contaT    = 1'b1;
        contaA    = 1'b1;
        registraA = 1'b1;
      end
      PISCA_ON: contaLedsOn = 1'b1;
      PISCA_OFF: begin
        contaLedsOff  = 1'b1;
        contaPiscadas = 1'b1;
      end
      PROXIMA: begin
        zeraA  = 1'b1;
        zeraR  = 1'b1;
        zeraL  = 1'b1;
        contaS = !fimS;
      end
      GANHOU: begin
        ganhou         = 1'b1;
        pronto         = 1'b1;
        displayFromMem = 1'b1;
        displayAddr    = MSG_GANHOU;
      end
      PERDEU: begin
        perdeu         = 1'b1;
        pronto         = 1'b1;
        displayFromMem = 1'b1;
        displayAddr    = perdeu_to_q ? MSG_TIMEOUT : MSG_ERRO;
      end
      default: ;
    endcase
  end

  assign db_estado = estado_q;

endmodule
